// File: rtl/alu_multibyte_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_multibyte_sequencer: drives an external 8-bit adder byte-serially to  |
// | build NBYTES-wide ADD/ADC/SUB/SBB results with C/Z/N/V flags.  Rev 1.0    |
// +--------------------------------------------------------------------------+
module alu_multibyte_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic [1:0]            in_op,
  input  logic                  in_carry,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_result,
  output logic                  out_c,
  output logic                  out_z,
  output logic                  out_n,
  output logic                  out_v
);

  localparam int W           = 8 * NBYTES;
  localparam int SW          = $clog2(W);
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic           zacc_q, zacc_d;
  logic [W-1:0]   result_q, result_d;
  logic           c_q, c_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
  logic           v_q, v_d;
  logic [SW-1:0]  bit_base;

  assign bit_base = SW'({idx_q, 3'b000});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    add_a    = 8'd0;
    add_b    = 8'd0;
    add_cin  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtraction is A + ~B + carry; the carry seed is 1 for SUB, flag for ADC/SBB.
          b_d     = in_op[1] ? ~in_b : in_b;
          carry_d = in_op[0] ? in_carry : in_op[1];
          idx_d   = 3'd0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[bit_base +: 8];
        add_b   = b_q[bit_base +: 8];
        add_cin = carry_q;
        result_d[bit_base +: 8] = add_sum;
        carry_d = add_cout;
        idx_d   = 3'(idx_q + 3'd1);
        zacc_d  = zacc_q & (add_sum == 8'd0);
        if (idx_q == LAST) begin
          c_d     = add_cout;
          v_d     = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
          n_d     = add_sum[7];
          z_d     = zacc_q && (add_sum == 8'd0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_c      = c_q;
  assign out_z      = z_q;
  assign out_n      = n_q;
  assign out_v      = v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multibyte_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_multibyte_sequencer: scoreboard bench for the NBYTES=2 sequencer  |
// | with a behavioural 8-bit adder.  Rev 1.0                                 |
// +--------------------------------------------------------------------------+
module tb_alu_multibyte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_op;
  logic        in_carry;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_c;
  logic        out_z;
  logic        out_n;
  logic        out_v;

  logic [8:0]  sum9;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;   // {C, Z, N, V}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum  = sum9[7:0];
  assign add_cout = sum9[8];

  alu_multibyte_sequencer #(.NBYTES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_carry   (in_carry),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_c      (out_c),
    .out_z      (out_z),
    .out_n      (out_n),
    .out_v      (out_v)
  );

  // Drives one request, waits for the result and completes the output handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic ci, output logic [15:0] res, output logic [3:0] fl,
                        output int lat, output logic cin1, output bit tmo);
    int g;
    g = 0;
    while (!in_ready && g < 10) begin
      @(posedge clk); #1; g++;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_carry = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; cin1 = 1'b0; tmo = 1'b0; res = '0; fl = '0;
    while (!out_valid && lat < 20) begin
      if (lat == 1) cin1 = add_cin;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      tmo = 1'b1;
    end else begin
      res = out_result;
      fl  = {out_c, out_z, out_n, out_v};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    n_cmp++;
    if (out_result !== 16'h0 || {out_c, out_z, out_n, out_v} !== 4'b0) begin
      n_err++; $display("FAIL reset_out: result=%h flags=%b, want 0000/0000",
                        out_result, {out_c, out_z, out_n, out_v});
    end
    n_cmp++;
    if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0) begin
      n_err++; $display("FAIL reset_adder: a=%h b=%h cin=%b, want 0", add_a, add_b, add_cin);
    end
  endtask

  // Plan vectors with hand-derived expectations: {a, b, op, cin, result, flags CZNV}.
  task automatic test_plan_vectors();
    logic [15:0] ta[9] = '{16'h00FF, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h1000,
                           16'hFFFF, 16'hFFFF, 16'h0102};
    logic [15:0] tb[9] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001,
                           16'h0000, 16'h0000, 16'h0304};
    logic [1:0]  top[9] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00};
    logic        tci[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] er[9] = '{16'h0100, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0FFE,
                           16'h0000, 16'hFFFF, 16'h0406};
    logic [3:0]  ef[9] = '{4'b0000, 4'b0011, 4'b1100, 4'b0010, 4'b1100, 4'b1000,
                           4'b1100, 4'b0010, 4'b0000};
    logic [15:0] res; logic [3:0] fl; int lat; logic cin1; bit tmo; exp_t e;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{res: er[i], fl: ef[i]});
      run_op(ta[i], tb[i], top[i], tci[i], res, fl, lat, cin1, tmo);
      e = sb.pop_front();
      n_cmp++;
      if (tmo || res !== e.res || fl !== e.fl) begin
        n_err++; $display("FAIL plan[%0d]: result=%h flags=%b tmo=%0d, want %h/%b",
                          i, res, fl, tmo, e.res, e.fl);
      end
      n_cmp++;
      if (lat !== 2) begin
        n_err++; $display("FAIL latency[%0d]: got %0d edges, want 2", i, lat);
      end
      if (i == 0) begin
        n_cmp++;
        if (cin1 !== 1'b1) begin
          n_err++; $display("FAIL chain_cin: add_cin in byte1=%b, want 1", cin1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, bb, res; logic [1:0] op; logic ci, c0; logic [16:0] full;
    logic [3:0] fl; int lat; logic cin1; bit tmo; exp_t e;
    for (int i = 0; i < 12; i++) begin
      a  = 16'($urandom); b = 16'($urandom); op = 2'($urandom_range(0, 3));
      ci = 1'($urandom_range(0, 1));
      bb = op[1] ? ~b : b;
      case (op)
        2'b00:   c0 = 1'b0;
        2'b10:   c0 = 1'b1;
        default: c0 = ci;
      endcase
      full = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
      sb.push_back('{res: full[15:0],
                     fl: {full[16], full[15:0] == 16'h0, full[15],
                          (a[15] == bb[15]) && (full[15] != a[15])}});
      run_op(a, b, op, ci, res, fl, lat, cin1, tmo);
      e = sb.pop_front();
      n_cmp++;
      if (tmo || res !== e.res || fl !== e.fl) begin
        n_err++; $display("FAIL rand[%0d] a=%h b=%h op=%0d ci=%b: result=%h flags=%b, want %h/%b",
                          i, a, b, op, ci, res, fl, e.res, e.fl);
      end
    end
  endtask

  task automatic test_backpressure();
    int g; exp_t e;
    sb.push_back('{res: 16'h3333, fl: 4'b0000});
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 2'b00; in_carry = 1'b0;
    @(posedge clk); #1;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 2'b11; in_carry = 1'b1;
    g = 0;
    while (!out_valid && g < 10) begin
      @(posedge clk); #1; g++;
    end
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.res ||
          {out_c, out_z, out_n, out_v} !== e.fl) begin
        n_err++; $display("FAIL hold[%0d]: valid=%b ready=%b result=%h flags=%b, want 1/0/%h/%b",
                          k, out_valid, in_ready, out_result, {out_c, out_z, out_n, out_v},
                          e.res, e.fl);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL ignored_req: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] res; logic [3:0] fl; int lat; logic cin1; bit tmo; exp_t e; bit seen;
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_op = 2'b00; in_carry = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0 ||
        {out_c, out_z, out_n, out_v} !== 4'b0 || add_cin !== 1'b0) begin
      n_err++; $display("FAIL abort: ready=%b valid=%b result=%h flags=%b cin=%b, want 1/0/0000/0000/0",
                        in_ready, out_valid, out_result, {out_c, out_z, out_n, out_v}, add_cin);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL abort_valid: out_valid pulsed=%b, want 0", seen);
    end
    sb.push_back('{res: 16'h0406, fl: 4'b0000});
    run_op(16'h0102, 16'h0304, 2'b00, 1'b0, res, fl, lat, cin1, tmo);
    e = sb.pop_front();
    n_cmp++;
    if (tmo || res !== e.res || fl !== e.fl || lat !== 2) begin
      n_err++; $display("FAIL post_reset: result=%h flags=%b lat=%0d, want %h/%b/2",
                        res, fl, lat, e.res, e.fl);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
